// File: rtl/m68k_bus_responder.sv
// 68000-bus target for the fx68k: window decode, programmable wait states, valid/ready
// backend handshake, DTACKn generation, and the system bus-error watchdog.
module m68k_bus_responder #(
   parameter logic [23:0] BASE_ADDR      = 24'h000000,
   parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
   parameter int unsigned WAIT_STATES    = 0,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        i_CLOCK,
   input  logic        i_RESET,
   input  logic [22:0] i_ADDR,
   input  logic        i_AS,
   input  logic        i_UDS,
   input  logic        i_LDS,
   input  logic        i_RW,
   input  logic [2:0]  i_FC,
   input  logic [15:0] i_DATA,
   input  logic        i_DTACK_BUS,
   output logic [15:0] o_DATA,
   output logic        o_DATA_OE,
   output logic        o_DTACK,
   output logic        o_BERR,
   output logic        o_MEM_REQ,
   output logic        o_MEM_WE,
   output logic [1:0]  o_MEM_BE,
   output logic [22:0] o_MEM_ADDR,
   output logic [2:0]  o_MEM_FC,
   output logic [15:0] o_MEM_WDATA,
   input  logic [15:0] i_MEM_RDATA,
   input  logic        i_MEM_READY
);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ACK, ST_DONE} state_t;

   localparam logic [3:0]  WAIT_INIT = WAIT_STATES[3:0];
   localparam logic [15:0] TIMEOUT   = TIMEOUT_CYCLES[15:0];

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] wd_cnt_q, wd_cnt_d, wd_inc;
   logic        rw_q, rw_d, abort_q, abort_d;
   logic        dtack_q, dtack_d, berr_q, berr_d;
   logic        data_oe_q, data_oe_d, req_q, req_d, we_q, we_d;
   logic [15:0] data_q, data_d, wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic [22:0] addr_q, addr_d;
   logic [2:0]  fc_q, fc_d;

   logic strobe_valid, addr_hit, ds_idle, dtack_set;

   assign strobe_valid = !i_AS && (!i_UDS || !i_LDS);
   assign addr_hit     = ((({i_ADDR, 1'b0} ^ BASE_ADDR) & ADDR_MASK & 24'hFFFFFE) == 24'h0);
   assign ds_idle      = i_AS || (i_UDS && i_LDS);
   // A cycle abandoned by the CPU still completes the backend handshake, silently.
   assign dtack_set    = (state_q == ST_ACCESS) && i_MEM_READY && !(abort_q || i_AS);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge i_CLOCK or negedge i_RESET) begin
      if (!i_RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wd_cnt_q  <= '0;
         rw_q      <= 1'b1;
         abort_q   <= 1'b0;
         dtack_q   <= 1'b1;
         berr_q    <= 1'b1;
         data_oe_q <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         data_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         addr_q    <= '0;
         fc_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wd_cnt_q  <= wd_cnt_d;
         rw_q      <= rw_d;
         abort_q   <= abort_d;
         dtack_q   <= dtack_d;
         berr_q    <= berr_d;
         data_oe_q <= data_oe_d;
         req_q     <= req_d;
         we_q      <= we_d;
         data_q    <= data_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         fc_q      <= fc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (strobe_valid && addr_hit) state_d = ST_WAIT;
         ST_WAIT:   if (i_AS) state_d = ST_IDLE;
                    else if (cnt_q == 4'd0) state_d = ST_ACCESS;
         ST_ACCESS: if (i_MEM_READY) state_d = dtack_set ? ST_ACK : ST_IDLE;
         ST_ACK:    if (ds_idle) state_d = ST_DONE;
         ST_DONE:   if (ds_idle) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: every signal gets a hold default first, so no path can infer a latch.
   always_comb begin
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      abort_d   = abort_q;
      dtack_d   = dtack_q;
      berr_d    = berr_q;
      data_oe_d = data_oe_q;
      req_d     = req_q;
      we_d      = we_q;
      data_d    = data_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      addr_d    = addr_q;
      fc_d      = fc_q;
      unique case (state_q)
         ST_IDLE: if (strobe_valid && addr_hit) begin
            addr_d  = i_ADDR;
            fc_d    = i_FC;
            rw_d    = i_RW;
            be_d    = {~i_UDS, ~i_LDS};
            wdata_d = i_DATA;
            cnt_d   = WAIT_INIT;
            abort_d = 1'b0;
         end
         ST_WAIT: if (!i_AS) begin
            if (cnt_q == 4'd0) begin
               req_d = 1'b1;
               we_d  = ~rw_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCESS: begin
            if (i_AS) abort_d = 1'b1;
            if (i_MEM_READY) begin
               req_d = 1'b0;
               if (dtack_set) begin
                  dtack_d = 1'b0;
                  if (rw_q) begin
                     data_d    = i_MEM_RDATA;
                     data_oe_d = 1'b1;
                  end
               end
            end
         end
         ST_ACK: if (ds_idle) begin
            dtack_d   = 1'b1;
            data_oe_d = 1'b0;
         end
         default: ;
      endcase

      // Watchdog frozen while local memory is busy, so a slow backend never raises BERRn.
      wd_inc = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
      if (i_AS || !i_DTACK_BUS)
         wd_cnt_d = '0;
      else if (state_q == ST_WAIT || state_q == ST_ACCESS)
         wd_cnt_d = wd_cnt_q;
      else
         wd_cnt_d = wd_inc;

      if (i_AS)
         berr_d = 1'b1;
      else if (TIMEOUT != 16'd0 && wd_cnt_d >= TIMEOUT && !dtack_set)
         berr_d = 1'b0;
   end

   assign o_DATA      = data_q;
   assign o_DATA_OE   = data_oe_q;
   assign o_DTACK     = dtack_q;
   assign o_BERR      = berr_q;
   assign o_MEM_REQ   = req_q;
   assign o_MEM_WE    = we_q;
   assign o_MEM_BE    = be_q;
   assign o_MEM_ADDR  = addr_q;
   assign o_MEM_FC    = fc_q;
   assign o_MEM_WDATA = wdata_q;

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- 68000-bus target (slave) for the fx68k asynchronous bus: decodes a memory window, inserts programmable wait states, runs a valid/ready handshake to a backing memory, and returns DTACKn.
- Also acts as the system bus watchdog: asserts BERRn when no responder acknowledges a cycle in time.
- Sits between the fx68k bus pins and an on-chip RAM/ROM or peripheral; same clock as the CPU, so inputs are sampled without synchronisers.

Parameters:
- BASE_ADDR, 24'h000000, window base; bit 0 ignored.
- ADDR_MASK, 24'hFF0000, decode mask; hit when (addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
- WAIT_STATES, 0, extra clocks between strobe detection and the memory request (0..15).
- TIMEOUT_CYCLES, 64, watchdog length in clocks; 0 disables BERRn generation.

Ports:
- i_CLOCK  in  1  system clock, shared with the CPU
- i_RESET  in  1  asynchronous, active-low reset
- i_ADDR  in  23  CPU address [23:1]
- i_AS  in  1  address strobe, active low
- i_UDS  in  1  upper data strobe (D15:8, even byte), active low
- i_LDS  in  1  lower data strobe (D7:0, odd byte), active low
- i_RW  in  1  1 = read, 0 = write
- i_FC  in  3  function code; latched for the backend only, not decoded
- i_DATA  in  16  CPU write data
- i_DTACK_BUS  in  1  wired-AND bus DTACKn (all responders), watchdog input
- o_DATA  out  16  read data to the CPU
- o_DATA_OE  out  1  drive o_DATA onto the bus
- o_DTACK  out  1  this block's DTACKn, active low
- o_BERR  out  1  bus error, active low
- o_MEM_REQ  out  1  backend request, held until accepted
- o_MEM_WE  out  1  backend write enable
- o_MEM_BE  out  2  byte enables {upper, lower}
- o_MEM_ADDR  out  23  latched word address
- o_MEM_FC  out  3  latched function code
- o_MEM_WDATA  out  16  latched write data
- i_MEM_RDATA  in  16  backend read data, valid with i_MEM_READY
- i_MEM_READY  in  1  backend accepts/completes the request

Behaviour:
- Reset (i_RESET low, asynchronous):
  - state = IDLE.
  - o_DTACK = 1, o_BERR = 1, o_DATA_OE = 0, o_MEM_REQ = 0, o_MEM_WE = 0, o_MEM_BE = 0, o_DATA = 0.
  - All counters cleared.
- A strobe is "valid" when i_AS = 0 and (i_UDS = 0 or i_LDS = 0).
- FSM states: IDLE, WAIT, ACCESS, ACK, DONE.
- IDLE:
  - On an edge with a valid strobe and an address hit, latch address, FC, RW, BE = {~i_UDS, ~i_LDS} and i_DATA.
  - Load cnt = WAIT_STATES and go to WAIT.
  - On a miss, stay in IDLE.
- WAIT:
  - If cnt == 0: o_MEM_REQ <= 1, o_MEM_WE <= ~RW, go to ACCESS.
  - Otherwise cnt <= cnt - 1.
- ACCESS:
  - o_MEM_REQ is held at 1 until i_MEM_READY is sampled at 1.
  - On that edge: o_MEM_REQ <= 0; on a read, o_DATA <= i_MEM_RDATA and o_DATA_OE <= 1; o_DTACK <= 0; go to ACK.
- ACK:
  - o_DTACK and o_DATA_OE are held.
  - Exit when i_AS = 1, or when both i_UDS and i_LDS = 1 (read-modify-write split).
  - On exit, the next edge sets o_DTACK <= 1, o_DATA_OE <= 0 and goes to DONE.
- DONE:
  - Go to IDLE when i_AS = 1, or when both DS are high with AS still low.
  - A read-modify-write write phase is a fresh cycle detected in IDLE.
  - A strobe must go inactive before it can re-trigger.
- Latency: DTACK falls WAIT_STATES + 2 edges after strobe detection when i_MEM_READY is already high.
- Abort: i_AS rising in WAIT returns to IDLE with no request issued.
  - i_AS rising in ACCESS does not drop o_MEM_REQ. The block finishes the backend handshake but does not assert o_DTACK, then returns to IDLE.
- Watchdog:
  - The counter increments each edge while i_AS = 0 and i_DTACK_BUS = 1. It clears when i_AS = 1 or i_DTACK_BUS = 0.
  - On reaching TIMEOUT_CYCLES, o_BERR <= 0 and is held until i_AS = 1, then released on the next edge.
  - The counter saturates and does not wrap.
- Simultaneous events: if DTACK assertion and the timeout occur on the same edge, DTACK wins and BERR stays high.
  - While this block's state is WAIT or ACCESS, the watchdog counter is frozen, so slow local memory never causes BERR.

Test Plan:
- Word read, WAIT_STATES=2, i_MEM_READY tied high, addr 0x000100 in window -> o_MEM_REQ high 3 edges after strobe, BE=2'b11, o_DTACK low 4 edges after strobe, o_DATA = i_MEM_RDATA (0xBEEF); o_DTACK high one edge after i_AS rises.
- Byte write, only i_LDS low, data 0x00A5 -> o_MEM_WE=1, o_MEM_BE=2'b01, o_MEM_WDATA=0x00A5, o_DATA_OE stays 0.
- Backend stall: i_MEM_READY low for 5 clocks -> o_MEM_REQ held high 5 clocks, DTACK delayed exactly 5 clocks, o_BERR stays high even with TIMEOUT_CYCLES=4.
- Unmapped access at 0xFF0000, TIMEOUT_CYCLES=8, nobody acks -> o_BERR low on the 8th edge, back high one edge after i_AS rises; this block never drives o_DTACK.
- TAS-style read-modify-write: AS held low, DS low/high/low with RW 1 then 0 -> two backend requests (read then write), two DTACK pulses.
- Async reset asserted in ACCESS -> all outputs reach their reset values without a clock edge; the next valid strobe is served normally.
